// File: rtl/i2s_capture.sv
// I2S receive path: masters pbck/plrck from slot_clk, deserialises up to 8 channels
// and streams whole frames as sign-extended 32-bit words; frames are delivered or dropped whole.
module i2s_capture #(
    parameter int unsigned CLK_RATIO   = 256,
    parameter int unsigned SAMPLE_BITS = 24
) (
    input  logic        slot_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        chan,
    output logic        pbck,
    output logic        plrck,
    input  logic [3:0]  pdata,
    output logic        aud_wr_valid,
    output logic [31:0] aud_wr_data,
    input  logic        aud_wr_ready,
    output logic        overflow,
    input  logic        overflow_clear,
    output logic [7:0]  frames_dropped
);

    localparam logic [9:0] LAST  = 10'(CLK_RATIO - 1);
    localparam logic [9:0] HALF  = 10'(CLK_RATIO / 2);
    localparam logic [9:0] DIV   = 10'(CLK_RATIO / 64);
    localparam logic [9:0] DHALF = 10'(CLK_RATIO / 128);
    localparam logic [9:0] SB    = 10'(SAMPLE_BITS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state, state_nx;
    logic [9:0]               cnt, phase, bidx;
    logic [2:0]               idx, idx_nx;
    logic                     n8, buf_n8;
    logic                     right_half, sample_now, frame_end;
    logic                     last_hs, commit, drop;
    logic [SAMPLE_BITS-1:0]   shreg [8];
    logic [SAMPLE_BITS-1:0]   obuf  [8];

    always_comb begin
        phase      = cnt % DIV;
        right_half = cnt >= HALF;
        bidx       = (cnt % HALF) / DIV;
        sample_now = enable && (phase == DHALF) && (bidx != '0) && (bidx <= SB);
        frame_end  = enable && (cnt == LAST);
    end

    always_ff @(posedge slot_clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            pbck  <= 1'b0;
            plrck <= 1'b0;
            n8    <= 1'b0;
        end else begin
            if (!enable || cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + 10'd1;
            pbck  <= enable && (phase >= DHALF);
            plrck <= enable && right_half;
            // Channel count chosen here applies to the frame that starts next.
            if (cnt == LAST)
                n8 <= chan;
        end
    end

    always_ff @(posedge slot_clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 8; i++)
                shreg[i] <= '0;
        end else if (sample_now) begin
            for (int unsigned l = 0; l < 4; l++) begin
                if (right_half)
                    shreg[2*l+1] <= SAMPLE_BITS'({shreg[2*l+1], pdata[l]});
                else
                    shreg[2*l]   <= SAMPLE_BITS'({shreg[2*l], pdata[l]});
            end
        end
    end

    // A commit coinciding with the final handshake counts as drained.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        last_hs  = (state == SEND) && aud_wr_ready && (idx == (buf_n8 ? 3'd7 : 3'd1));
        commit   = frame_end && ((state == IDLE) || last_hs);
        drop     = frame_end && !commit;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_nx = SEND;
                    idx_nx   = '0;
                end
            end
            SEND: begin
                if (commit) begin
                    idx_nx = '0;
                end else if (last_hs) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else if (aud_wr_ready) begin
                    idx_nx = idx + 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge slot_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_ff @(posedge slot_clk or negedge reset) begin
        if (!reset) begin
            buf_n8         <= 1'b0;
            overflow       <= 1'b0;
            frames_dropped <= '0;
            for (int unsigned i = 0; i < 8; i++)
                obuf[i] <= '0;
        end else begin
            if (commit) begin
                buf_n8 <= n8;
                for (int unsigned c = 0; c < 8; c++)
                    if (c < 2 || n8)
                        obuf[c] <= shreg[c];
            end
            if (drop) begin
                overflow <= 1'b1;
                if (frames_dropped != '1)
                    frames_dropped <= frames_dropped + 8'd1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    assign aud_wr_valid = (state == SEND);
    assign aud_wr_data  = {{(32-SAMPLE_BITS){obuf[idx][SAMPLE_BITS-1]}}, obuf[idx]};

endmodule
